// File: rtl/axis_read_responder_pkg.sv
// Shared constants, FSM state type and beat arithmetic for the read responder.
package axis_read_responder_pkg;

   localparam int BYTES_PER_BEAT = 64;
   localparam int BEAT_SHIFT     = 6;
   localparam int BEAT_CNT_WIDTH = 59;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      STREAM = 2'd1,
      DONE   = 2'd2
   } state_t;

   // Whole beats covering nbytes; a partial trailing beat counts as a full one.
   function automatic logic [BEAT_CNT_WIDTH-1:0] bytes_to_beats(input logic [63:0] nbytes);
      return {1'b0, nbytes[63:BEAT_SHIFT]} + BEAT_CNT_WIDTH'(|nbytes[BEAT_SHIFT-1:0]);
   endfunction

endpackage

// File: rtl/axis_skid_fifo.sv
// Two-entry FIFO that parks beats the stream consumer has not yet taken.
module axis_skid_fifo #(
   parameter int WIDTH = 513
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] pop_data,
   output logic             full,
   output logic             empty,
   output logic [1:0]       count
);

   localparam int DEPTH = 2;

   logic             wr_ptr_reg;
   logic             rd_ptr_reg;
   logic [1:0]       count_reg;
   logic             do_push;
   logic             do_pop;
   logic [WIDTH-1:0] entry_q [DEPTH];

   // Pushing into a full FIFO or popping an empty one is dropped rather than corrupting state.
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;

   genvar gi;
   generate
      for (gi = 0; gi < DEPTH; gi++) begin : g_entry
         logic [WIDTH-1:0] data_reg;

         // Each slot captures push data when the write pointer selects it.
         always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
               data_reg <= '0;
            end else if (do_push && (wr_ptr_reg == 1'(gi))) begin
               data_reg <= push_data;
            end
         end

         assign entry_q[gi] = data_reg;
      end
   endgenerate

   // Pointers toggle between the two slots; count tracks occupancy 0..2.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr_reg <= 1'b0;
         rd_ptr_reg <= 1'b0;
         count_reg  <= 2'd0;
      end else begin
         if (do_push) begin
            wr_ptr_reg <= ~wr_ptr_reg;
         end
         if (do_pop) begin
            rd_ptr_reg <= ~rd_ptr_reg;
         end
         count_reg <= count_reg + {1'b0, do_push} - {1'b0, do_pop};
      end
   end

   assign pop_data = entry_q[rd_ptr_reg];
   assign full     = (count_reg == 2'd2);
   assign empty    = (count_reg == 2'd0);
   assign count    = count_reg;

endmodule

// File: rtl/axis_read_responder.sv
// Streams a block of local memory out over AXI-Stream, one 64-byte beat per word.
// Read data arriving while the FIFO is empty goes straight to the stream so a
// two-deep credit window is enough to sustain one beat per cycle.
module axis_read_responder
   import axis_read_responder_pkg::*;
#(
   parameter int DATA_WIDTH     = 512,
   parameter int MEM_ADDR_WIDTH = 16
) (
   input  logic                      clk,
   input  logic                      reset_n,
   input  logic                      ctrl_start,
   output logic                      ctrl_done,
   input  logic [63:0]               ctrl_addr_offset,
   input  logic [63:0]               ctrl_xfer_size_in_bytes,
   output logic                      busy,
   output logic                      mem_rd_en,
   output logic [MEM_ADDR_WIDTH-1:0] mem_rd_addr,
   input  logic [DATA_WIDTH-1:0]     mem_rd_data,
   output logic                      m_axis_tvalid,
   input  logic                      m_axis_tready,
   output logic [DATA_WIDTH-1:0]     m_axis_tdata,
   output logic                      m_axis_tlast
);

   localparam int FIFO_WIDTH = DATA_WIDTH + 1;

   state_t                      state_reg;
   logic                        busy_reg;
   logic                        done_reg;
   logic [MEM_ADDR_WIDTH-1:0]   base_reg;
   logic [BEAT_CNT_WIDTH-1:0]   beats_reg;
   logic [BEAT_CNT_WIDTH-1:0]   issued_reg;
   logic                        rd_valid_reg;
   logic                        rd_last_reg;

   logic                        fifo_push;
   logic                        fifo_pop;
   logic                        fifo_full;
   logic                        fifo_empty;
   logic [1:0]                  fifo_count;
   logic [FIFO_WIDTH-1:0]       fifo_head;
   logic [1:0]                  pending;
   logic                        rd_issue;
   logic                        out_valid;
   logic                        out_last;
   logic [DATA_WIDTH-1:0]       out_data;
   logic                        handshake;
   logic                        unused_addr_bits;

   // Only the word-address slice of the byte offset is meaningful here.
   assign unused_addr_bits = ^{ctrl_addr_offset[63:MEM_ADDR_WIDTH+BEAT_SHIFT],
                               ctrl_addr_offset[BEAT_SHIFT-1:0]};

   // Beats parked in the FIFO plus the read landing this cycle; new reads only while this stays below 2.
   assign pending  = fifo_count + {1'b0, rd_valid_reg};
   assign rd_issue = (state_reg == STREAM) && (issued_reg < beats_reg)
                     && !fifo_full && (pending < 2'd2);

   assign mem_rd_en   = rd_issue;
   assign mem_rd_addr = rd_issue ? (base_reg + issued_reg[MEM_ADDR_WIDTH-1:0]) : '0;

   // Stream head: oldest FIFO entry, else the read data arriving this cycle.
   assign out_valid = !fifo_empty || rd_valid_reg;
   assign out_data  = fifo_empty ? mem_rd_data : fifo_head[DATA_WIDTH-1:0];
   assign out_last  = fifo_empty ? rd_last_reg : fifo_head[DATA_WIDTH];
   assign handshake = out_valid && m_axis_tready;

   assign m_axis_tvalid = out_valid;
   assign m_axis_tdata  = out_valid ? out_data : '0;
   assign m_axis_tlast  = out_valid && out_last;

   // Arriving data is parked unless it is consumed directly from an empty FIFO.
   assign fifo_push = rd_valid_reg && !(fifo_empty && m_axis_tready);
   assign fifo_pop  = handshake && !fifo_empty;

   axis_skid_fifo #(
      .WIDTH (FIFO_WIDTH)
   ) u_fifo (
      .clk       (clk),
      .reset_n   (reset_n),
      .push      (fifo_push),
      .push_data ({rd_last_reg, mem_rd_data}),
      .pop       (fifo_pop),
      .pop_data  (fifo_head),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .count     (fifo_count)
   );

   // Track the one-cycle memory latency and tag the final beat of the transfer.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rd_valid_reg <= 1'b0;
         rd_last_reg  <= 1'b0;
      end else begin
         rd_valid_reg <= rd_issue;
         rd_last_reg  <= rd_issue && (issued_reg == beats_reg - BEAT_CNT_WIDTH'(1));
      end
   end

   // Transfer sequencing: latch the request, count issued reads, pulse done once.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_reg  <= IDLE;
         busy_reg   <= 1'b0;
         done_reg   <= 1'b0;
         base_reg   <= '0;
         beats_reg  <= '0;
         issued_reg <= '0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (ctrl_start) begin
                  base_reg   <= ctrl_addr_offset[MEM_ADDR_WIDTH+BEAT_SHIFT-1:BEAT_SHIFT];
                  beats_reg  <= bytes_to_beats(ctrl_xfer_size_in_bytes);
                  issued_reg <= '0;
                  busy_reg   <= 1'b1;
                  if (ctrl_xfer_size_in_bytes == 64'd0) begin
                     state_reg <= DONE;
                     done_reg  <= 1'b1;
                  end else begin
                     state_reg <= STREAM;
                  end
               end
            end
            STREAM: begin
               if (rd_issue) begin
                  issued_reg <= issued_reg + BEAT_CNT_WIDTH'(1);
               end
               if (handshake && out_last) begin
                  state_reg <= DONE;
                  done_reg  <= 1'b1;
               end
            end
            DONE: begin
               state_reg <= IDLE;
               busy_reg  <= 1'b0;
               done_reg  <= 1'b0;
            end
            default: begin
               state_reg <= IDLE;
               busy_reg  <= 1'b0;
               done_reg  <= 1'b0;
            end
         endcase
      end
   end

   assign busy      = busy_reg;
   assign ctrl_done = done_reg;

endmodule
